// File: rtl/alu_pkg.sv
// Shared encodings and types for the 8-bit datapath ALU.
package alu_pkg;

  typedef enum logic [1:0] {
    OpAdd  = 2'b00,
    OpAnd  = 2'b01,
    OpNot  = 2'b10,
    OpPass = 2'b11
  } alu_op_e;

  typedef enum logic [2:0] {
    SelImm5   = 3'b000,
    SelPcImm6 = 3'b001,
    SelReg    = 3'b010
  } src_sel_e;

  typedef struct packed {
    logic n;
    logic z;
    logic p;
  } flags_t;

  localparam flags_t CcReset = '{n: 1'b0, z: 1'b1, p: 1'b0};

  function automatic logic [7:0] sext6(input logic [5:0] v);
    return {{2{v[5]}}, v};
  endfunction

endpackage

// File: rtl/alu_operand_mux.sv
// Immediate/PC extension and A/B operand selection for the ALU.
module alu_operand_mux
  import alu_pkg::*;
(
  input  logic [2:0] source_sel,
  input  logic [5:0] ins_immediate,
  input  logic [5:0] pc,
  input  logic [7:0] reg_sr1_out,
  input  logic [7:0] reg_sr2_out,
  output logic [7:0] op_a,
  output logic [7:0] op_b
);

  logic [7:0] imm5;
  logic [7:0] imm6;
  logic [7:0] pc8;

  // imm5 reuses the 6-bit extender by replicating bit 4 into bit 5.
  assign imm5 = sext6({ins_immediate[4], ins_immediate[4:0]});
  assign imm6 = sext6(ins_immediate);
  assign pc8  = {2'b00, pc};

  always_comb begin
    op_a = reg_sr1_out;
    op_b = 8'h00;
    case (source_sel)
      SelImm5: begin
        op_a = reg_sr1_out;
        op_b = imm5;
      end
      SelPcImm6: begin
        op_a = pc8;
        op_b = imm6;
      end
      SelReg: begin
        op_a = reg_sr1_out;
        op_b = reg_sr2_out;
      end
      default: begin
        op_a = reg_sr1_out;
        op_b = 8'h00;
      end
    endcase
  end

endmodule

// File: rtl/alu.sv
// Combinational 8-bit ALU with N/Z/P flags and a clocked condition-code register.
module alu
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] alu_op,
  input  logic [2:0] source_sel,
  input  logic [5:0] ins_immediate,
  input  logic [5:0] pc,
  input  logic [7:0] reg_sr1_out,
  input  logic [7:0] reg_sr2_out,
  input  logic       load_cc,
  output logic [7:0] result,
  output logic       negative,
  output logic       zero,
  output logic       positive,
  output logic       cc_n,
  output logic       cc_z,
  output logic       cc_p
);

  logic [7:0] op_a;
  logic [7:0] op_b;
  flags_t     flags;
  flags_t     cc_d;
  flags_t     cc_q;

  alu_operand_mux u_operand_mux (
    .source_sel    (source_sel),
    .ins_immediate (ins_immediate),
    .pc            (pc),
    .reg_sr1_out   (reg_sr1_out),
    .reg_sr2_out   (reg_sr2_out),
    .op_a          (op_a),
    .op_b          (op_b)
  );

  always_comb begin
    result = op_b;
    case (alu_op)
      OpAdd:  result = op_a + op_b;
      OpAnd:  result = op_a & op_b;
      // NOT-register inverts sr1; the immediate forms invert the B operand.
      OpNot:  result = (source_sel == SelReg) ? ~reg_sr1_out : ~op_b;
      OpPass: result = op_b;
      default: result = op_b;
    endcase
  end

  always_comb begin
    flags.n = result[7];
    flags.z = (result == 8'h00);
    flags.p = !result[7] && (result != 8'h00);
  end

  assign negative = flags.n;
  assign zero     = flags.z;
  assign positive = flags.p;

  always_comb begin
    cc_d = cc_q;
    if (load_cc) begin
      cc_d = flags;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cc_q <= CcReset;
    end else begin
      cc_q <= cc_d;
    end
  end

  assign cc_n = cc_q.n;
  assign cc_z = cc_q.z;
  assign cc_p = cc_q.p;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed plan vectors plus randomized model comparison.
module tb_alu;

  logic       clk;
  logic       rst;
  logic [1:0] alu_op;
  logic [2:0] source_sel;
  logic [5:0] ins_immediate;
  logic [5:0] pc;
  logic [7:0] reg_sr1_out;
  logic [7:0] reg_sr2_out;
  logic       load_cc;
  logic [7:0] result;
  logic       negative;
  logic       zero;
  logic       positive;
  logic       cc_n;
  logic       cc_z;
  logic       cc_p;

  int checks = 0;
  int errors = 0;

  alu dut (
    .clk           (clk),
    .rst           (rst),
    .alu_op        (alu_op),
    .source_sel    (source_sel),
    .ins_immediate (ins_immediate),
    .pc            (pc),
    .reg_sr1_out   (reg_sr1_out),
    .reg_sr2_out   (reg_sr2_out),
    .load_cc       (load_cc),
    .result        (result),
    .negative      (negative),
    .zero          (zero),
    .positive      (positive),
    .cc_n          (cc_n),
    .cc_z          (cc_z),
    .cc_p          (cc_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model in plain integer arithmetic.
  function automatic logic [7:0] model_result(input logic [1:0] op, input logic [2:0] sel,
                                              input logic [5:0] imm, input logic [5:0] pcv,
                                              input logic [7:0] sr1, input logic [7:0] sr2);
    int i5, i6, a, b, r;
    i5 = int'(imm[4:0]);
    if (i5 >= 16) i5 = i5 - 32;
    i6 = int'(imm);
    if (i6 >= 32) i6 = i6 - 64;
    if (sel == 3'd0)      begin a = int'(sr1); b = i5; end
    else if (sel == 3'd1) begin a = int'(pcv); b = i6; end
    else if (sel == 3'd2) begin a = int'(sr1); b = int'(sr2); end
    else                  begin a = int'(sr1); b = 0; end
    if (op == 2'd0)      r = (a + b + 512) % 256;
    else if (op == 2'd1) r = (a & b) & 255;
    else if (op == 2'd2) r = (sel == 3'd2) ? (~a & 255) : (~b & 255);
    else                 r = b & 255;
    return 8'(r);
  endfunction

  function automatic logic [2:0] model_flags(input logic [7:0] r);
    int v;
    v = int'(r);
    return {v >= 128, v == 0, (v > 0) && (v < 128)};
  endfunction

  task automatic drive(input logic [1:0] op, input logic [2:0] sel, input logic [5:0] imm,
                       input logic [5:0] pcv, input logic [7:0] sr1, input logic [7:0] sr2);
    alu_op        = op;
    source_sel    = sel;
    ins_immediate = imm;
    pc            = pcv;
    reg_sr1_out   = sr1;
    reg_sr2_out   = sr2;
    #1;
  endtask

  task automatic test_reset();
    drive(2'b00, 3'b010, 6'd0, 6'd0, 8'd52, 8'd74);
    checks++;
    if ({cc_n, cc_z, cc_p} !== 3'b010) begin
      errors++;
      $display("FAIL reset_cc: got %b expected 010", {cc_n, cc_z, cc_p});
    end
    checks++;
    if (result !== 8'h7E || {negative, zero, positive} !== 3'b001) begin
      errors++;
      $display("FAIL reset_result: got %h/%b expected 7e/001", result,
               {negative, zero, positive});
    end
  endtask

  task automatic test_directed();
    logic [1:0] op_t  [10] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b01, 2'b01,
                               2'b00, 2'b00};
    logic [2:0] sel_t [10] = '{3'b000, 3'b010, 3'b010, 3'b010, 3'b010, 3'b000, 3'b010,
                               3'b000, 3'b001, 3'b010};
    logic [5:0] imm_t [10] = '{6'b010100, 6'd0, 6'd0, 6'd0, 6'd0, 6'b010100, 6'd0,
                               6'b010100, 6'd20, 6'd0};
    logic [5:0] pc_t  [10] = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd28, 6'd0};
    logic [7:0] sr1_t [10] = '{8'd52, 8'd52, 8'h00, 8'h01, 8'h34, 8'h00, 8'h34, 8'h34,
                               8'h00, 8'h7F};
    logic [7:0] sr2_t [10] = '{8'h00, 8'd74, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h4A, 8'h00,
                               8'h00, 8'h01};
    logic [7:0] exp_r [10] = '{8'h28, 8'h7E, 8'hFF, 8'h00, 8'hCB, 8'h0B, 8'h00, 8'h34,
                               8'h30, 8'h80};
    logic [2:0] exp_f [10] = '{3'b001, 3'b001, 3'b100, 3'b010, 3'b100, 3'b001, 3'b010,
                               3'b001, 3'b001, 3'b100};
    for (int i = 0; i < 10; i++) begin
      drive(op_t[i], sel_t[i], imm_t[i], pc_t[i], sr1_t[i], sr2_t[i]);
      checks++;
      if (result !== exp_r[i] || {negative, zero, positive} !== exp_f[i]) begin
        errors++;
        $display("FAIL directed_%0d: got %h/%b expected %h/%b", i, result,
                 {negative, zero, positive}, exp_r[i], exp_f[i]);
      end
    end
  endtask

  task automatic test_reserved_sel();
    for (int s = 3; s < 8; s++) begin
      for (int op = 0; op < 4; op++) begin
        drive(2'(op), 3'(s), 6'(s * 7), 6'd5, 8'(8'h90 + s), 8'h5A);
        checks++;
        if (result !== model_result(2'(op), 3'(s), 6'(s * 7), 6'd5, 8'(8'h90 + s), 8'h5A)) begin
          errors++;
          $display("FAIL reserved_sel%0d_op%0d: got %h expected %h", s, op, result,
                   model_result(2'(op), 3'(s), 6'(s * 7), 6'd5, 8'(8'h90 + s), 8'h5A));
        end
      end
    end
  endtask

  task automatic test_cc();
    @(negedge clk);
    drive(2'b00, 3'b001, 6'd20, 6'd28, 8'h00, 8'h00);
    load_cc = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({cc_n, cc_z, cc_p} !== 3'b001) begin
      errors++;
      $display("FAIL cc_load_pos: got %b expected 001", {cc_n, cc_z, cc_p});
    end
    @(negedge clk);
    load_cc = 1'b0;
    drive(2'b10, 3'b010, 6'd0, 6'd0, 8'h34, 8'h00);
    @(posedge clk);
    #1;
    checks++;
    if ({cc_n, cc_z, cc_p} !== 3'b001) begin
      errors++;
      $display("FAIL cc_hold: got %b expected 001", {cc_n, cc_z, cc_p});
    end
    @(negedge clk);
    load_cc = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({cc_n, cc_z, cc_p} !== 3'b100) begin
      errors++;
      $display("FAIL cc_load_neg: got %b expected 100", {cc_n, cc_z, cc_p});
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({cc_n, cc_z, cc_p} !== 3'b010) begin
      errors++;
      $display("FAIL cc_async_reset: got %b expected 010", {cc_n, cc_z, cc_p});
    end
    drive(2'b00, 3'b010, 6'd0, 6'd0, 8'd1, 8'd2);
    @(posedge clk);
    #1;
    checks++;
    if ({cc_n, cc_z, cc_p} !== 3'b010) begin
      errors++;
      $display("FAIL cc_reset_wins: got %b expected 010", {cc_n, cc_z, cc_p});
    end
    checks++;
    if (result !== 8'h03 || {negative, zero, positive} !== 3'b001) begin
      errors++;
      $display("FAIL result_in_reset: got %h/%b expected 03/001", result,
               {negative, zero, positive});
    end
    @(negedge clk);
    rst     = 1'b0;
    load_cc = 1'b0;
  endtask

  task automatic test_random();
    logic [2:0] exp_cc;
    logic [7:0] er;
    logic [2:0] ef;
    exp_cc = {cc_n, cc_z, cc_p};
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      load_cc = 1'($urandom_range(0, 1));
      drive(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 6'($urandom),
            6'($urandom), 8'($urandom), 8'($urandom));
      er = model_result(alu_op, source_sel, ins_immediate, pc, reg_sr1_out, reg_sr2_out);
      ef = model_flags(er);
      checks++;
      if (result !== er || {negative, zero, positive} !== ef) begin
        errors++;
        $display("FAIL random_%0d op=%b sel=%b imm=%h pc=%h sr1=%h sr2=%h: got %h/%b expected %h/%b",
                 i, alu_op, source_sel, ins_immediate, pc, reg_sr1_out, reg_sr2_out,
                 result, {negative, zero, positive}, er, ef);
      end
      if (load_cc) exp_cc = ef;
      @(posedge clk);
      #1;
      checks++;
      if ({cc_n, cc_z, cc_p} !== exp_cc) begin
        errors++;
        $display("FAIL random_cc_%0d: got %b expected %b", i, {cc_n, cc_z, cc_p}, exp_cc);
      end
    end
    load_cc = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    load_cc = 1'b0;
    drive(2'b00, 3'b000, 6'd0, 6'd0, 8'd0, 8'd0);
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_directed();
    test_reserved_sel();
    test_cc();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
